// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin two-requester write sequencer for a register bank with registered one-hot write flags
module reg_write_arbiter #(
  parameter int NREGS   = 8,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [15:0]       data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       data1,
  output logic              ack1,
  output logic [NREGS-1:0]  w_flag,
  output logic [15:0]       w_data,
  output logic              grant_id,
  output logic              err
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_n;
  logic pri, pri_n, win, eff0, eff1, hit;
  logic [ADDR_W-1:0] addr_w;
  logic [15:0] data_w;
  logic [NREGS-1:0] flag_n;
  // grant_id is refreshed on every issue, so it names the requester being acked
  assign ack0 = (state == ISSUE) & ~grant_id;
  assign ack1 = (state == ISSUE) & grant_id;
  always_comb begin
    eff0 = req0 & ~ack0;
    eff1 = req1 & ~ack1;
    win = (eff0 & eff1) ? pri : eff1;
    state_n = (eff0 | eff1) ? ISSUE : IDLE;
    pri_n = (state_n == ISSUE) ? ~win : pri;
    addr_w = win ? addr1 : addr0;
    data_w = win ? data1 : data0;
    flag_n = '0;
    hit = 1'b0;
    for (int i = 0; i < NREGS; i++)
      if (addr_w == i[ADDR_W-1:0]) begin
        hit = 1'b1;
        flag_n[i] = !(ZERO_R0 != 0 && i == 0);
      end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      pri <= 1'b0;
      grant_id <= 1'b0;
      w_flag <= '0;
      w_data <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      pri <= pri_n;
      w_flag <= (state_n == ISSUE) ? flag_n : '0;
      err <= (state_n == ISSUE) & ~hit;
      if (state_n == ISSUE) grant_id <= win;
      if (state_n == ISSUE && |flag_n) w_data <= data_w;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Write-port arbiter and sequencer for the 16-bit register bank built from per-register write-enabled 16-bit registers. It shares the bank's single write path between two requesters, requester 0 (ALU writeback) and requester 1 (memory load). Each cycle it grants at most one write, using round-robin priority and a req/ack handshake. It drives one-hot per-register write flags and the shared write data, both registered.

## Interface
- NREGS, 8: number of registers in the bank, 2..16.
- ADDR_W, 3: register address width; 2^ADDR_W >= NREGS.
- ZERO_R0, 1: when 1, register 0 is read-only; writes to it are acknowledged and suppressed.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0  in  1  requester 0 write request; held until ack0.
- addr0  in  ADDR_W  requester 0 target register.
- data0  in  16  requester 0 write data (signed two's complement, passed unmodified).
- ack0  out  1  one-cycle pulse: requester 0's request was consumed.
- req1, addr1, data1, ack1: same as above, for requester 1.
- w_flag  out  NREGS  one-hot write enables, one bit per register's write flag.
- w_data  out  16  data shared by all registers.
- grant_id  out  1  requester served by the current ack/w_flag cycle.
- err  out  1  one-cycle pulse: the consumed request had addr >= NREGS.

## Operation
- Effective request: eff_i = req_i AND NOT ack_i. A requester's request is masked in the cycle its ack is high, so a held request is never written twice.
- Round-robin pointer `pri` (1 bit), which names the favoured requester. Reset value: 0.
- Arbitration in cycle N:
  - If only one eff_i is high, that requester wins.
  - If both are high, requester `pri` wins.
  - On a win, `pri` is set to the loser (NOT winner). `pri` is unchanged when nothing wins.
- Issue in cycle N+1 (registered from the cycle N decision), exactly one of the following:
  - Normal write: w_flag[addr_win]=1, w_data=data_win, ack_win=1, grant_id=win.
  - addr_win >= NREGS: ack_win=1, err=1, w_flag all 0.
  - ZERO_R0=1 and addr_win==0: ack_win=1, w_flag all 0, err=0.
- In any cycle with no issue: w_flag=0, ack0=ack1=0, err=0. grant_id and w_data hold their last values.
- Behaviour is a two-state FSM per cycle:
  - IDLE: no winner latched; outputs quiet.
  - ISSUE: winner latched; outputs driven this cycle.
  - Transitions: ISSUE is entered whenever any eff_i is high at the edge; otherwise IDLE.
  - ISSUE→ISSUE is legal, so back-to-back writes are allowed.
- Same-address collision (both requesters target the same register in the same cycle): the winner writes first, the loser writes in the following cycle. The final value is the loser's data.
- Requester protocol:
  - addr_i and data_i must be stable from req_i rise until ack_i is seen.
  - The requester deasserts req_i, or presents a new request, in the cycle after ack_i.
  - Dropping req_i before ack_i withdraws the request if no grant has been issued yet. Once granted (cycle N), the issue in N+1 still occurs.

## Timing
- Reset: when rst_n=0 at a rising edge, all of the following clear at that edge:
  - w_flag=0, w_data=0, ack0=ack1=0, err=0, grant_id=0, pri=0, FSM=IDLE.
  - A grant latched in the cycle before reset is discarded: no write and no ack.
  - A requester still holding req is re-arbitrated normally after rst_n returns high.
- Latency: req high at edge N → w_flag/ack high during cycle N+1 → the target register captures w_data at the edge ending N+1.
- Throughput:
  - Single requester with continuous req: one write every 2 cycles, because of the ack-cycle mask.
  - Both requesting continuously: one write per cycle, alternating 0,1,0,1.
- Outputs are registered only; there is no combinational path from req/addr/data to w_flag/w_data/ack.
- Starvation bound: a pending request is issued within 3 cycles of req rise.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req0=1, addr0=2, data0=16'h1234 → w_flag=0 and ack0=0 throughout. After release: w_flag=8'b00000100, w_data=16'h1234, ack0=1 in the 2nd cycle after rst_n high.
- Single requester held: req1=1, addr1=5, data1=16'hFFFF for 6 cycles → ack1 and w_flag[5] pulse in cycles 2, 4, 6 only. grant_id=1 in each of those cycles.
- Contention from reset: req0=req1=1 continuously, addr0=1, addr1=3 → grant_id sequence 0,1,0,1 in consecutive cycles. w_flag alternates 8'b00000010 / 8'b00001000. Never two ack bits high in one cycle.
- Collision: both requesters target addr 4 in the same cycle, data0=16'h000A, data1=16'h000B, pri=0 → w_data=16'h000A then 16'h000B in consecutive cycles. The final register value is 16'h000B.
- Illegal and zero address: with NREGS=8, ADDR_W=4, addr0=9 → ack0=1, err=1, w_flag=0. Then addr0=0 with ZERO_R0=1 → ack0=1, err=0, w_flag=0.
- Reset mid-operation: req0 rises with addr0=6, and rst_n=0 at the next edge → no w_flag[6] pulse and no ack0. After rst_n returns high with req0 still held, the write is issued 2 cycles later.
